// File: rtl/iter_alu.sv
// iter_alu: registered multi-cycle ALU with single-cycle ops plus shift-add multiply.
// Define ITER_ALU_DIV_EN to include the restoring divider for op 101 (otherwise op 101 is illegal).
module iter_alu #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_res,
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [1:0]   i_sc,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_z,
    output logic [W-1:0] o_zh,
    output logic [1:0]   o_s,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_ONE, S_RUN} state_t;
    state_t r_state, w_next;

    logic [W-1:0]  r_x, r_y, r_hi, r_lo, r_z, r_zh;
    logic [1:0]    r_sc, r_s;
    logic [CW-1:0] r_cnt;
    logic          r_busy, r_done, r_err;
    logic          w_isRun, w_oneErr;
    logic [W-1:0]  w_oneZ, w_oneZh, w_stepHi, w_stepLo;
    logic [W:0]    w_mulSum;
`ifdef ITER_ALU_DIV_EN
    logic          r_isDiv, w_ge;
    logic [W:0]    w_shift;
    logic [W-1:0]  w_divHi;
`endif

    function automatic logic [1:0] calcFlags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] sel);
        logic [W-1:0] diff;
        logic [W-1:0] cmp;
        diff = a - b;
        case (sel)
            2'b00:   cmp = W'(2);
            2'b01:   cmp = '0;
            default: cmp = b;
        endcase
        return {a == cmp, diff[W-1]};
    endfunction

`ifdef ITER_ALU_DIV_EN
    assign w_isRun = (i_op == 3'b100) || ((i_op == 3'b101) && (i_y != '0));
`else
    assign w_isRun = (i_op == 3'b100);
`endif

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // ONE doubles as the done cycle, so a new start is accepted from it as well as from IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:   if (r_cnt == LAST) w_next = S_IDLE;
            default: w_next = i_start ? (w_isRun ? S_RUN : S_ONE) : S_IDLE;
        endcase
    end

    always_comb begin
        w_oneZ   = '0;
        w_oneZh  = '0;
        w_oneErr = 1'b0;
        case (i_op)
            3'b000:  w_oneZ = i_x;
            3'b001:  w_oneZ = i_y + W'(1);
            3'b010:  w_oneZ = i_x - i_y;
            3'b011:  w_oneZ = W'(2);
`ifdef ITER_ALU_DIV_EN
            3'b101: begin
                w_oneZ   = '1;
                w_oneZh  = i_x;
                w_oneErr = 1'b1;
            end
`endif
            default: w_oneErr = 1'b1;
        endcase
    end

    // r_hi/r_lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_y} : '0);
        w_stepHi = w_mulSum[W:1];
        w_stepLo = {w_mulSum[0], r_lo[W-1:1]};
`ifdef ITER_ALU_DIV_EN
        w_shift  = {r_hi, r_lo[W-1]};
        w_ge     = (w_shift >= {1'b0, r_y});
        w_divHi  = w_ge ? (w_shift[W-1:0] - r_y) : w_shift[W-1:0];
        if (r_isDiv) begin
            w_stepHi = w_divHi;
            w_stepLo = {r_lo[W-2:0], w_ge};
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_x    <= '0;
            r_y    <= '0;
            r_sc   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
            r_z    <= '0;
            r_zh   <= '0;
            r_s    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef ITER_ALU_DIV_EN
            r_isDiv <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_hi  <= w_stepHi;
                    r_lo  <= w_stepLo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_z    <= w_stepLo;
                        r_zh   <= w_stepHi;
                        r_s    <= calcFlags(r_x, r_y, r_sc);
                        r_err  <= 1'b0;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                default: begin
                    if (i_start) begin
                        r_x  <= i_x;
                        r_y  <= i_y;
                        r_sc <= i_sc;
`ifdef ITER_ALU_DIV_EN
                        r_isDiv <= (i_op == 3'b101);
`endif
                        if (w_isRun) begin
                            r_busy <= 1'b1;
                            r_cnt  <= '0;
                            r_hi   <= '0;
                            r_lo   <= i_x;
                        end else begin
                            r_z    <= w_oneZ;
                            r_zh   <= w_oneZh;
                            r_err  <= w_oneErr;
                            r_s    <= calcFlags(i_x, i_y, i_sc);
                            r_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_z    = r_z;
    assign o_zh   = r_zh;
    assign o_s    = r_s;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;
endmodule

// File: doc/iter_alu.md
# iter_alu

Parametrised multi-cycle ALU for the lab datapath; successor to the 16-bit combinational transfer/increment/subtract/constant unit with its equality and sign flags. It keeps those single-cycle operations and flag semantics. It adds:
- registered outputs;
- a start/busy/done handshake;
- iterative unsigned multiply (shift-add) and divide (restoring), so controller FSMs can offload loops.

## Interface
- W, 16, operand/result width (W ≥ 4)
- clk  in  1  clock, rising edge
- res  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only when busy=0
- op  in  3  000 pass x, 001 y+1, 010 x−y, 011 const 2, 100 mul, 101 div, 110/111 illegal
- sc  in  2  compare select for s[1]: 00→2, 01→0, 10/11→y
- x, y  in  W  operands, captured at accepted start
- z  out  W  result / product low / quotient
- zh  out  W  product high / remainder; 0 for ops 000–011
- s  out  2  s[0]=MSB of (x−y) mod 2^W, s[1]=(x==cmp)
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, results valid
- err  out  1  illegal op or divide-by-zero, valid with done

## Operation
- States:
  - IDLE → ONE on start with op ∉ {100,101}, or op=101 with y=0 (div disabled: see Configuration).
  - IDLE → RUN on start with op=100, or op=101 with y≠0.
  - ONE → IDLE.
  - RUN → IDLE after W step cycles.
- x, y, op are latched on the accepted start. s is computed from the latched operands and registered with z.
- ONE results:
  - op 000: z=x
  - op 001: z=(y+1) mod 2^W
  - op 010: z=(x−y) mod 2^W
  - op 011: z=2
  - all four: zh=0, err=0
  - illegal op: z=0, zh=0, err=1
  - divide-by-zero: z=all ones, zh=x, err=1
- Multiply: unsigned, 2W-bit product {zh,z}. One multiplier bit per cycle, LSB first.
- Divide: unsigned restoring, one quotient bit per cycle. z=x/y, zh=x mod y.
- z, zh, s, err hold their values until the next done. Intermediate iteration values never appear on z/zh.
- start while busy=1 is ignored, with no effect on the operation in flight. start in the done cycle (busy=0) is accepted.
- Reset at any time (mid-RUN included):
  - state IDLE, counter 0;
  - z, zh, s, busy, done, err all 0.

## Timing
- Accepted start at edge n:
  - ONE ops: done=1 and results valid in cycle n+1.
  - RUN ops: busy=1 cycles n+1..n+W; done=1 and results valid in cycle n+W+1, with busy=0 in that cycle.
- done is high for exactly one cycle per accepted start.
- busy is never high in the same cycle as done.
- Back-to-back: start held high continuously yields one operation per (latency) cycles with no lost or duplicated done.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- ITER_ALU_DIV_EN defined:
  - op 101 performs the divide as above.
- Not defined:
  - divider datapath omitted;
  - op 101 is treated as illegal (ONE path: z=0, zh=0, err=1, done at n+1).
  - All other ops are unchanged.

## Test plan
- W=16, op=010, x=5, y=7, sc=10 → done at n+1, z=0xFFFE, zh=0, s=01, err=0. Repeat with op=000, x=2, sc=00 → z=0x0002, s[1]=1.
- op=100, x=0x1234, y=0x0100 → busy n+1..n+16, done at n+17 with z=0x3400, zh=0x0012, err=0.
- ITER_ALU_DIV_EN defined:
  - op=101, x=100, y=7 → done at n+17, z=14, zh=2.
  - op=101, x=100, y=0 → done at n+1, z=0xFFFF, zh=100, err=1.
  - Without the macro: op=101, x=100, y=7 → done at n+1, z=0, zh=0, err=1.
- During a multiply (x=3, y=5), pulse start at n+4 with op=000, x=9 → ignored; done only at n+17 with z=15, zh=0.
- Assert res at cycle n+5 of a multiply → all outputs 0 immediately. After release, op=001, y=0xFFFF → done one cycle later, z=0x0000.
- op=110 and op=111 → done at n+1, z=0, zh=0, err=1. Following op=011 → z=2, err=0.
